// File: rtl/dnn_accel_pkg.sv
// Shared types and bank geometry for the DNN accelerator bank arbiter.
package dnn_accel_pkg;

    localparam int BANK_ADDR_W = 10;
    localparam int BANK_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/bank_arb_grant.sv
// Combinational round-robin grant with a bounded hold for the current owner.
module bank_arb_grant
    import dnn_accel_pkg::*;
#(
    parameter int HOLD_MAX = 4
) (
    input  logic [1:0] state,
    input  logic       last,
    input  logic [3:0] hold_cnt,
    input  logic       req0,
    input  logic       req1,
    output logic       gnt0,
    output logic       gnt1
);

    localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

    // Owner keeps the bank until it stops asking or exhausts its hold while
    // the other master is waiting; from IDLE a tie goes to the non-last master.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OWN0: begin
                if (req0 && (!req1 || hold_cnt < HOLD_LIM)) gnt0 = 1'b1;
                else if (req1)                              gnt1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (!req0 || hold_cnt < HOLD_LIM)) gnt1 = 1'b1;
                else if (req0)                              gnt0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    gnt0 = last;
                    gnt1 = ~last;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

endmodule

// File: rtl/dnn_accel_bank_arbiter.sv
// Two-master arbiter sharing one single-port bank (1-cycle read latency).
module dnn_accel_bank_arbiter
    import dnn_accel_pkg::*;
#(
    parameter int ADDR_W   = BANK_ADDR_W,
    parameter int DATA_W   = BANK_DATA_W,
    parameter int BE_W     = DATA_W / 8,
    parameter int HOLD_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] bank_address,
    output logic [BE_W-1:0]   bank_byteenable,
    output logic              bank_chipselect,
    output logic              bank_write,
    output logic [DATA_W-1:0] bank_writedata,
    output logic              bank_clken,
    input  logic [DATA_W-1:0] bank_readdata
);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic       rd_pend_q, rd_pend_d;
    logic       rd_id_q, rd_id_d;

    logic req0, req1, gnt0_raw, gnt1_raw, g0, g1;
    logic owner_again, other_req;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    bank_arb_grant #(.HOLD_MAX(HOLD_MAX)) u_grant (
        .state    (state_q),
        .last     (last_q),
        .hold_cnt (hold_q),
        .req0     (req0),
        .req1     (req1),
        .gnt0     (gnt0_raw),
        .gnt1     (gnt1_raw)
    );

    // Nothing is accepted while reset is held.
    assign g0 = gnt0_raw & ~reset;
    assign g1 = gnt1_raw & ~reset;

    // Next ownership, hold count and read-return bookkeeping.
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        hold_d      = hold_q;
        rd_id_d     = rd_id_q;
        owner_again = (state_q == OWN0 && g0) || (state_q == OWN1 && g1);
        other_req   = g0 ? req1 : req0;
        rd_pend_d   = (g0 & m0_read & ~m0_write) | (g1 & m1_read & ~m1_write);
        if (g0 || g1) begin
            state_d = g1 ? OWN1 : OWN0;
            last_d  = g1;
            if (owner_again && other_req)
                hold_d = (hold_q == 4'd15) ? hold_q : hold_q + 4'd1;
            else
                hold_d = 4'd1;
            if (rd_pend_d) rd_id_d = g1;
        end else begin
            state_d = IDLE;
        end
    end

    // State registers; last=1 so m0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            hold_q    <= 4'd0;
            rd_pend_q <= 1'b0;
            rd_id_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            hold_q    <= hold_d;
            rd_pend_q <= rd_pend_d;
            rd_id_q   <= rd_id_d;
        end
    end

    // Bank mux: m1's fields when it holds the grant, otherwise m0's.
    always_comb begin
        bank_address    = g1 ? m1_address    : m0_address;
        bank_byteenable = g1 ? m1_byteenable : m0_byteenable;
        bank_writedata  = g1 ? m1_writedata  : m0_writedata;
        bank_chipselect = g0 | g1;
        bank_write      = (g0 & m0_write) | (g1 & m1_write);
    end

    assign bank_clken       = 1'b1;
    assign m0_waitrequest   = ~g0;
    assign m1_waitrequest   = ~g1;
    assign m0_readdata      = bank_readdata;
    assign m1_readdata      = bank_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_id_q & ~reset;
    assign m1_readdatavalid = rd_pend_q &  rd_id_q & ~reset;

endmodule

// File: tb/tb_dnn_accel_bank_arbiter.sv
// Directed bench with a read-return scoreboard for dnn_accel_bank_arbiter.
module tb_dnn_accel_bank_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  m0_address, m1_address, bank_address;
    logic [3:0]  m0_byteenable, m1_byteenable, bank_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic        bank_chipselect, bank_write, bank_clken;
    logic [31:0] bank_writedata, bank_readdata;

    always #5 clk = ~clk;

    dnn_accel_bank_arbiter #(.HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .bank_address(bank_address), .bank_byteenable(bank_byteenable),
        .bank_chipselect(bank_chipselect), .bank_write(bank_write),
        .bank_writedata(bank_writedata), .bank_clken(bank_clken),
        .bank_readdata(bank_readdata)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 7)    return 32'h1122_3344;
        if (i == 1023) return 32'hDEAD_03FF;
        return 32'(i);
    endfunction

    // Bank behavioural model: byte-enabled write, registered read.
    logic [31:0] bank_mem [1024];
    initial begin
        for (int i = 0; i < 1024; i++) bank_mem[i] = init_word(i);
        bank_readdata = '0;
        forever begin
            @(posedge clk);
            if (bank_chipselect) begin
                if (bank_write) begin
                    for (int b = 0; b < 4; b++)
                        if (bank_byteenable[b]) bank_mem[bank_address][8*b +: 8] = bank_writedata[8*b +: 8];
                end else begin
                    bank_readdata = bank_mem[bank_address];
                end
            end
        end
    end

    typedef struct { logic id; logic [31:0] data; } rd_t;
    rd_t         sb[$];
    logic [31:0] ref_mem [1024];
    int          n_chk = 0, n_pass = 0;
    logic        s_w0, s_w1, s_cs, s_bw, s_rdv1;
    logic [9:0]  s_ba;
    logic [31:0] s_rd1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_write(input logic [9:0] a, input logic [3:0] be, input logic [31:0] d);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    // One cycle: sample at negedge, score returns, log acceptances, advance.
    task automatic step();
        rd_t e;
        @(negedge clk);
        s_w0 = m0_waitrequest; s_w1 = m1_waitrequest;
        s_cs = bank_chipselect; s_bw = bank_write; s_ba = bank_address;
        s_rdv1 = m1_readdatavalid; s_rd1 = m1_readdata;
        if (reset) begin
            chk("rdv_in_reset", {30'd0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
            sb.delete();
        end else begin
            chk("rdv0", {31'd0, m0_readdatavalid}, {31'd0, sb.size() > 0 && sb[0].id == 1'b0});
            chk("rdv1", {31'd0, m1_readdatavalid}, {31'd0, sb.size() > 0 && sb[0].id == 1'b1});
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.id ? "rdata1" : "rdata0", e.id ? m1_readdata : m0_readdata, e.data);
            end
            if ((m0_read | m0_write) && !m0_waitrequest) begin
                if (m0_write) model_write(m0_address, m0_byteenable, m0_writedata);
                else sb.push_back('{1'b0, ref_mem[m0_address]});
            end
            if ((m1_read | m1_write) && !m1_waitrequest) begin
                if (m1_write) model_write(m1_address, m1_byteenable, m1_writedata);
                else sb.push_back('{1'b1, ref_mem[m1_address]});
            end
        end
        @(posedge clk); #1;
    endtask

    int grant_of, run0, run1, max0, max1;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
        reset = 1'b1;
        m0_address = '0; m0_byteenable = 4'hF; m0_read = 1'b1; m0_write = 1'b0; m0_writedata = '0;
        m1_address = '0; m1_byteenable = 4'hF; m1_read = 1'b1; m1_write = 1'b0; m1_writedata = '0;

        // Reset: requests present but nothing accepted.
        step();
        chk("rst_wait0", {31'd0, s_w0}, 32'd1);
        chk("rst_wait1", {31'd0, s_w1}, 32'd1);
        chk("rst_cs", {30'd0, s_cs, s_bw}, 32'd0);
        step();
        reset = 1'b0; m0_read = 1'b0; m1_read = 1'b0;
        step();

        // Simultaneous first writes: m0 first, then m1.
        m0_write = 1'b1; m0_address = 10'd100; m0_writedata = 32'hCAFE_0000;
        m1_write = 1'b1; m1_address = 10'd101; m1_writedata = 32'hBEEF_0001;
        step();
        chk("tie_wait0", {31'd0, s_w0}, 32'd0);
        chk("tie_wait1", {31'd0, s_w1}, 32'd1);
        chk("tie_bw0", {31'd0, s_bw}, 32'd1);
        m0_write = 1'b0;
        step();
        chk("tie2_wait1", {31'd0, s_w1}, 32'd0);
        chk("tie2_bw1", {31'd0, s_bw}, 32'd1);
        m1_write = 1'b0;
        step();

        // Single m0 read of address 5.
        m0_read = 1'b1; m0_address = 10'd5;
        step();
        chk("rd5_wait0", {31'd0, s_w0}, 32'd0);
        m0_read = 1'b0;
        step();

        // Byte-enable merge into address 7, read back by m1.
        m1_write = 1'b1; m1_address = 10'd7; m1_writedata = 32'hAABB_CCDD; m1_byteenable = 4'b0011;
        step();
        chk("be_wr_wait1", {31'd0, s_w1}, 32'd0);
        m1_write = 1'b0; m1_read = 1'b1; m1_byteenable = 4'hF;
        step();
        chk("be_rd_wait1", {31'd0, s_w1}, 32'd0);
        m1_read = 1'b0;
        step();
        chk("be_merge", s_rd1, 32'h1122_CCDD);
        step();

        // Bounded hold: both masters saturate with reads.
        m0_read = 1'b1; m0_address = 10'd10;
        m1_read = 1'b1; m1_address = 10'd20;
        run0 = 0; run1 = 0; max0 = 0; max1 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            grant_of = !s_w0 ? 0 : (!s_w1 ? 1 : 2);
            chk($sformatf("hold_gnt%0d", i), 32'(grant_of), (i < 4 || i >= 8) ? 32'd0 : 32'd1);
            run0 = s_w0 ? run0 + 1 : 0; if (run0 > max0) max0 = run0;
            run1 = s_w1 ? run1 + 1 : 0; if (run1 > max1) max1 = run1;
        end
        chk("hold_max_wait0", 32'(max0), 32'd4);
        chk("hold_max_wait1", 32'(max1), 32'd4);
        m0_read = 1'b0; m1_read = 1'b0;
        step();

        // Back-to-back m1 reads at the address extremes.
        m1_read = 1'b1; m1_address = 10'd1023;
        step();
        chk("b2b_addr", {22'd0, s_ba}, 32'd1023);
        m1_address = 10'd0;
        step();
        chk("b2b_wait1", {31'd0, s_w1}, 32'd0);
        chk("b2b_rd1023", {s_rd1[31:1], s_rdv1}, {32'hDEAD_03FF} | 32'd1);
        m1_read = 1'b0;
        step();
        chk("b2b_rd0", {s_rd1[31:1], s_rdv1}, 32'd1);

        // Reset right after an accepted read drops its return.
        m0_read = 1'b1; m0_address = 10'd5;
        step();
        chk("rr_wait0", {31'd0, s_w0}, 32'd0);
        reset = 1'b1; m0_address = 10'd3; m1_read = 1'b1; m1_address = 10'd4;
        step();
        chk("rr_rst_wait", {30'd0, s_w0, s_w1}, 32'd3);
        chk("rr_rst_cs", {31'd0, s_cs}, 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("rr_tie_wait0", {31'd0, s_w0}, 32'd0);
        chk("rr_tie_wait1", {31'd0, s_w1}, 32'd1);
        m0_read = 1'b0;
        step();
        chk("rr_m1_wait1", {31'd0, s_w1}, 32'd0);
        m1_read = 1'b0;
        step();
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dnn_accel_bank_arbiter.md
# dnn_accel_bank_arbiter

Two-master arbiter that shares one single-port on-chip bank (1024 x 32, byte-enabled, one-cycle read latency) between the host-side Avalon-MM master (m0) and the accelerator datapath master (m1). It grants one transfer per cycle using round-robin with a bounded hold, drives the bank's chipselect, write, address and byteenable, and routes returned read data with `readdatavalid` to the master that issued the read. It sits between the interconnect or accelerator fetch logic and each bank instance.

## Interface
- `ADDR_W`, 10: bank word-address width (1024 words).
- `DATA_W`, 32: data width.
- `BE_W`, 4: byteenable width, `DATA_W/8`.
- `HOLD_MAX`, 4: maximum consecutive transfers for the owner while the other master waits. Legal range is 1 to 15.

- `clk`  in  1: clock.
- `reset`  in  1: reset. Reset is synchronous and active-high.
- `mX_address`  in  ADDR_W: word address, where X is 0 or 1.
- `mX_byteenable`  in  BE_W: byte lanes.
- `mX_read`, `mX_write`  in  1: request strobes, held until accepted.
- `mX_writedata`  in  DATA_W: write data.
- `mX_waitrequest`  out  1: high means not accepted this cycle.
- `mX_readdata`  out  DATA_W: read data.
- `mX_readdatavalid`  out  1: read data valid.
- `bank_address`  out  ADDR_W.
- `bank_byteenable`  out  BE_W.
- `bank_chipselect`, `bank_write`  out  1.
- `bank_writedata`  out  DATA_W.
- `bank_clken`  out  1: tied high.
- `bank_readdata`  in  DATA_W: bank output, unregistered, valid one cycle after address.

## Operation
- `reqX = mX_read | mX_write`. If read and write are both high, the transfer is a write and the read is ignored.
- State is `IDLE`, `OWN0` or `OWN1`. Registers:
  - `last`: last owner, 1 bit.
  - `hold_cnt`: 4 bits.
  - `rd_pend`: 1 bit.
  - `rd_id`: 1 bit.
- Grant is combinational from state and requests:
  - In `IDLE`: a single requester is granted. When both request, grant `~last`.
  - In `OWNk`:
    - Grant k if `reqk` and either the other master is not requesting or `hold_cnt < HOLD_MAX`.
    - Otherwise grant the other master if it is requesting.
    - Otherwise no grant.
- Next state:
  - A grant to j moves to `OWNj` and sets `last = j`.
  - No grant moves to `IDLE`, and `last` is kept.
- `hold_cnt`:
  - Set to 1 when ownership changes, or on a grant out of `IDLE`.
  - Incremented when the owner is granted again while the other master requests.
  - Set to 1 when the owner is granted and the other master is idle.
  - Saturates at 15.
- Granted master j:
  - `mj_waitrequest = 0`.
  - The bank is driven from j's address, byteenable and writedata.
  - `bank_chipselect = 1`; `bank_write = mj_write`.
  - Non-granted requesters see `waitrequest = 1`.
  - With no grant, both waitrequests are 1 and `bank_chipselect = bank_write = 0`.
- Accepted read: `rd_pend <= 1`, `rd_id <= j`. Otherwise `rd_pend <= 0`.
- Read return:
  - `m{rd_id}_readdatavalid = rd_pend`.
  - Both `mX_readdata = bank_readdata`, unqualified.
- While `reset` is high:
  - Both waitrequests are 1.
  - `bank_chipselect = bank_write = 0`.
  - Both readdatavalids are 0.
- Reset values:
  - State `IDLE`, `last = 1` (m0 wins the first tie), `hold_cnt = 0`, `rd_pend = 0`.
  - A read accepted in the cycle before reset asserts returns no readdatavalid.
- The arbiter applies no address arithmetic. Addresses pass through unchanged; 1023 and 0 are ordinary addresses with no wrap handling.

## Timing
- Accept latency is 0 cycles. A request is accepted in the cycle it is presented if granted.
- Read latency: `readdatavalid` is asserted exactly 1 cycle after acceptance.
- Throughput is one transfer per cycle, including back-to-back reads from either master or alternating masters.
- Writes take effect at the clock edge of acceptance. A read accepted the next cycle returns the new data.
- Worst-case wait for a requester while the other master saturates is `HOLD_MAX` cycles.

## Structure
- `dnn_accel_pkg` holds:
  - enum `arb_state_e` {`IDLE`, `OWN0`, `OWN1`};
  - constants `BANK_ADDR_W = 10` and `BANK_DATA_W = 32`.
- One sub-module, `bank_arb_grant`, holds the combinational grant decision. Inputs are state, `last`, `hold_cnt`, `req0`, `req1`; outputs are `gnt0`, `gnt1`. State registers and the bank mux stay in the top.

## Test plan
- Single read after reset, bank preloaded with mem[5]=0x0000_0005: m0 read address 5 → m0_waitrequest=0 in the same cycle; m0_readdatavalid=1 the next cycle with 0x0000_0005; m1_readdatavalid stays 0.
- Simultaneous first requests after reset: m0 and m1 write in the same cycle → m0 accepted in cycle 0, m1 accepted in cycle 1; bank_write high in both cycles.
- Bounded hold: both masters read continuously with HOLD_MAX=4 → grant pattern m0×4, m1×4, m0×4; no waitrequest stretch exceeds 4 cycles.
- Byte-enable merge: mem[7]=0x1122_3344; m1 write 0xAABB_CCDD with byteenable 4'b0011; then m1 read address 7 → readdata 0x1122_CCDD.
- Reset mid-read: m0 read accepted, and reset is high the following cycle → no readdatavalid on either master; waitrequest=1 while reset is high; after release, state is IDLE and a tie goes to m0.
- Back-to-back returns: m1 reads address 1023 then address 0 in consecutive cycles → m1_readdatavalid high for 2 consecutive cycles with mem[1023] then mem[0].
